// File: rtl/rom_dl_pkg.sv
// rtl/rom_dl_pkg.sv - shared types and helpers for the ROM download router
package rom_dl_pkg;

   localparam int IOCTL_AW = 25;

   typedef enum logic [1:0] {IDLE, LOAD, FINISH} dl_state_e;

   // 32 bits covers the largest region count; callers truncate to NUM_REGIONS.
   function automatic logic [31:0] onehot_region(input logic [IOCTL_AW-1:0] idx);
      logic [31:0] v;
      v = '0;
      if (idx < IOCTL_AW'(32)) v[idx[4:0]] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/rom_dl_packer.sv
// rtl/rom_dl_packer.sv - byte pairing and ROM write output register stage
// OUT_W=16 pairs even/odd bytes little-endian; OUT_W=8 is a plain register.
module rom_dl_packer #(
   parameter int NUM_REGIONS = 10,
   parameter int REGION_AW   = 12,
   parameter int OUT_W       = 8
) (
   input  logic                                CLK,
   input  logic                                RESET_N,
   input  logic                                i_clear,
   input  logic                                i_valid,
   input  logic [NUM_REGIONS-1:0]              i_region_oh,
   input  logic [REGION_AW-1:0]                i_off,
   input  logic [7:0]                          i_byte,
   output logic [NUM_REGIONS-1:0]              o_cs,
   output logic [REGION_AW-(OUT_W/16)-1:0]     o_addr,
   output logic [OUT_W-1:0]                    o_data,
   output logic                                o_wr
);

   generate
      if (OUT_W == 16) begin : g_pack16
         logic [7:0] r_pend;
         logic       w_fire;

         assign w_fire = i_valid && !i_clear && i_off[0];

         always_ff @(posedge CLK or negedge RESET_N) begin
            if (!RESET_N) begin
               r_pend <= '0;
               o_cs   <= '0;
               o_addr <= '0;
               o_data <= '0;
               o_wr   <= 1'b0;
            end else begin
               o_wr <= w_fire;
               o_cs <= w_fire ? i_region_oh : '0;
               if (i_clear) begin
                  r_pend <= '0;
               end else if (i_valid) begin
                  // Zeroing pending after use makes a lone odd byte pair with 0x00.
                  if (i_off[0]) begin
                     o_addr <= i_off[REGION_AW-1:1];
                     o_data <= {i_byte, r_pend};
                     r_pend <= '0;
                  end else begin
                     r_pend <= i_byte;
                  end
               end
            end
         end
      end else begin : g_pass8
         logic w_fire;

         assign w_fire = i_valid && !i_clear;

         always_ff @(posedge CLK or negedge RESET_N) begin
            if (!RESET_N) begin
               o_cs   <= '0;
               o_addr <= '0;
               o_data <= '0;
               o_wr   <= 1'b0;
            end else begin
               o_wr <= w_fire;
               o_cs <= w_fire ? i_region_oh : '0;
               if (w_fire) begin
                  o_addr <= i_off;
                  o_data <= i_byte;
               end
            end
         end
      end
   endgenerate

endmodule

// File: rtl/rom_dl_router.sv
// rtl/rom_dl_router.sv - routes an ioctl download stream into N equal ROM regions
// Optional running byte checksum: define ROM_DL_CHECKSUM_EN.
module rom_dl_router
   import rom_dl_pkg::*;
#(
   parameter int          NUM_REGIONS = 10,
   parameter int          REGION_AW   = 12,
   parameter int unsigned BASE_ADDR   = 0,
   parameter int          DL_INDEX    = 0,
   parameter int          OUT_W       = 8
) (
   input  logic                              CLK,
   input  logic                              RESET_N,
   input  logic                              ioctl_download,
   input  logic [7:0]                        ioctl_index,
   input  logic [IOCTL_AW-1:0]               ioctl_addr,
   input  logic [7:0]                        ioctl_dout,
   input  logic                              ioctl_wr,
   output logic [NUM_REGIONS-1:0]            rom_cs,
   output logic [REGION_AW-(OUT_W/16)-1:0]   rom_addr,
   output logic [OUT_W-1:0]                  rom_data,
   output logic                              rom_wr,
   output logic                              busy,
   output logic                              done,
   output logic                              short_load,
   output logic                              out_of_range,
   output logic [IOCTL_AW-1:0]               bytes_loaded,
   output logic [15:0]                       checksum
);

   localparam logic [31:0]          TOTAL  = 32'(NUM_REGIONS) << REGION_AW;
   localparam logic [IOCTL_AW-1:0]  BASE_A = IOCTL_AW'(BASE_ADDR);
   localparam logic [7:0]           IDX    = 8'(DL_INDEX);

   dl_state_e              r_state;
   logic                   r_dl_d;
   logic                   r_busy;
   logic                   r_done;
   logic                   r_short;
   logic                   r_oor;
   logic [IOCTL_AW-1:0]    r_bytes;

   logic [IOCTL_AW-1:0]    w_off;
   logic                   w_in_range;
   logic                   w_accept;
   logic                   w_start;
   logic                   w_fall;
   logic                   w_clear;
   logic                   w_short;
   logic [NUM_REGIONS-1:0] w_region_oh;

   assign w_off       = ioctl_addr - BASE_A;
   assign w_in_range  = (ioctl_addr >= BASE_A) && ({7'd0, w_off} < TOTAL);
   assign w_accept    = (r_state == LOAD) && ioctl_wr && w_in_range;
   assign w_start     = (r_state == IDLE) && ioctl_download && !r_dl_d && (ioctl_index == IDX);
   assign w_fall      = !ioctl_download && r_dl_d;
   // FINISH also clears so a dangling even byte never leaks into the next load.
   assign w_clear     = w_start || (r_state == FINISH);
   assign w_short     = {7'd0, r_bytes} < TOTAL;
   assign w_region_oh = NUM_REGIONS'(onehot_region(w_off >> REGION_AW));

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state <= IDLE;
         r_dl_d  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_short <= 1'b0;
         r_oor   <= 1'b0;
         r_bytes <= '0;
      end else begin
         r_dl_d <= ioctl_download;
         case (r_state)
            IDLE: begin
               if (w_start) begin
                  r_state <= LOAD;
                  r_busy  <= 1'b1;
                  r_done  <= 1'b0;
                  r_short <= 1'b0;
                  r_oor   <= 1'b0;
                  r_bytes <= '0;
               end
            end
            LOAD: begin
               if (ioctl_wr) begin
                  if (!w_in_range) r_oor <= 1'b1;
                  else if (r_bytes != {IOCTL_AW{1'b1}}) r_bytes <= r_bytes + 1'b1;
               end
               if (w_fall) begin
                  r_state <= FINISH;
                  r_busy  <= 1'b0;
               end
            end
            FINISH: begin
               r_short <= w_short;
               r_done  <= !w_short && !r_oor;
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef ROM_DL_CHECKSUM_EN
   logic [15:0] r_checksum;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N)      r_checksum <= '0;
      else if (w_start)  r_checksum <= '0;
      else if (w_accept) r_checksum <= r_checksum + {8'd0, ioctl_dout};
   end

   assign checksum = r_checksum;
`else
   assign checksum = 16'h0000;
`endif

   rom_dl_packer #(
      .NUM_REGIONS (NUM_REGIONS),
      .REGION_AW   (REGION_AW),
      .OUT_W       (OUT_W)
   ) u_packer (
      .CLK         (CLK),
      .RESET_N     (RESET_N),
      .i_clear     (w_clear),
      .i_valid     (w_accept),
      .i_region_oh (w_region_oh),
      .i_off       (w_off[REGION_AW-1:0]),
      .i_byte      (ioctl_dout),
      .o_cs        (rom_cs),
      .o_addr      (rom_addr),
      .o_data      (rom_data),
      .o_wr        (rom_wr)
   );

   assign busy         = r_busy;
   assign done         = r_done;
   assign short_load   = r_short;
   assign out_of_range = r_oor;
   assign bytes_loaded = r_bytes;

endmodule
